// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares the single-port RAM between the multicycle CPU datapath and the
//   program/debug loader. Every access runs through IDLE -> ISSUE -> WAIT ->
//   DONE. The winner's read data is returned in its own register, and a
//   one-cycle done strobe tells that requester its access has completed.
//
//   Optional build macro: RAM_ARB_STARVE_GUARD_EN
//     Defined   : a burst counter lets the loader win after MAX_BURST
//                 consecutive CPU grants made while the loader was waiting.
//     Undefined : strict CPU priority, and the burst counter is not built.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   cpuReq/cpuWrite/cpuAddress/    CPU request (held until cpuDone),
//   cpuDataIn                      write flag, address and write data
//   cpuDataOut, cpuDone            registered CPU read data, completion pulse
//   ldrReq/ldrWrite/ldrAddress/    loader request (held until ldrDone),
//   ldrDataIn                      write flag, address and write data
//   ldrDataOut, ldrDone            registered loader read data, completion pulse
//   ramAddress/ramIsReading/       RAM address, isReading (0 = write)
//   ramDataIn                      and write data
//   ramDataOut                     RAM read data
//   owner                          current grant: 00 none, 01 CPU, 10 loader
module ram_arbiter #(
  parameter int ADDRESS_SIZE = 20,
  parameter int WORD_SIZE    = 64,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpuReq,
  input  logic                    cpuWrite,
  input  logic [ADDRESS_SIZE-1:0] cpuAddress,
  input  logic [WORD_SIZE-1:0]    cpuDataIn,
  output logic [WORD_SIZE-1:0]    cpuDataOut,
  output logic                    cpuDone,
  input  logic                    ldrReq,
  input  logic                    ldrWrite,
  input  logic [ADDRESS_SIZE-1:0] ldrAddress,
  input  logic [WORD_SIZE-1:0]    ldrDataIn,
  output logic [WORD_SIZE-1:0]    ldrDataOut,
  output logic                    ldrDone,
  output logic [ADDRESS_SIZE-1:0] ramAddress,
  output logic                    ramIsReading,
  output logic [WORD_SIZE-1:0]    ramDataIn,
  input  logic [WORD_SIZE-1:0]    ramDataOut,
  output logic [1:0]              owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} StateType;

  localparam logic [1:0] OwnerNone = 2'b00;
  localparam logic [1:0] OwnerCpu  = 2'b01;
  localparam logic [1:0] OwnerLdr  = 2'b10;

  localparam int WaitWidth = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  StateType             state;
  StateType             nextState;
  logic                 grantCpu;
  logic                 grantLdr;
  logic                 latchedWrite;
  logic [WaitWidth-1:0] waitCount;
  logic                 lastWait;
  logic                 starveTrip;

  assign lastWait = (waitCount == WaitWidth'(READ_LATENCY - 1));

`ifdef RAM_ARB_STARVE_GUARD_EN
  localparam int BurstWidth = ($clog2(MAX_BURST + 1) > 3) ? $clog2(MAX_BURST + 1) : 3;

  logic [BurstWidth-1:0] burstCount;

  // starveTrip can only matter when both requests are pending, because the
  // grant logic looks at it only on that path.
  assign starveTrip = (burstCount == BurstWidth'(MAX_BURST));

  // The counter tracks CPU grants the loader has had to watch. It restarts
  // whenever the loader is served or stops asking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burstCount <= '0;
    end else if (state == IDLE) begin
      if (grantLdr || !ldrReq) begin
        burstCount <= '0;
      end else if (grantCpu) begin
        burstCount <= burstCount + 1'b1;
      end
    end
  end
`else
  assign starveTrip = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next state and grant selection. Requests are looked at only in IDLE.
  // The CPU wins ties unless the starvation guard has tripped.
  always_comb begin
    nextState = state;
    grantCpu  = 1'b0;
    grantLdr  = 1'b0;
    case (state)
      IDLE: begin
        if (ldrReq && (!cpuReq || starveTrip)) begin
          grantLdr = 1'b1;
        end else if (cpuReq) begin
          grantCpu = 1'b1;
        end
        if (grantCpu || grantLdr) begin
          nextState = ISSUE;
        end
      end
      ISSUE:   nextState = WAIT;
      WAIT:    if (lastWait) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Datapath registers. The RAM address and write data are latched at grant
  // time and held until the next grant. ramIsReading drops only for the
  // ISSUE cycle of a write. Read data is captured on the last WAIT cycle,
  // so the done pulse in DONE arrives together with valid data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner        <= OwnerNone;
      cpuDone      <= 1'b0;
      ldrDone      <= 1'b0;
      cpuDataOut   <= '0;
      ldrDataOut   <= '0;
      ramAddress   <= '0;
      ramDataIn    <= '0;
      ramIsReading <= 1'b1;
      latchedWrite <= 1'b0;
      waitCount    <= '0;
    end else begin
      cpuDone <= 1'b0;
      ldrDone <= 1'b0;
      case (state)
        IDLE: begin
          waitCount <= '0;
          if (grantCpu) begin
            ramAddress   <= cpuAddress;
            ramDataIn    <= cpuDataIn;
            latchedWrite <= cpuWrite;
            ramIsReading <= ~cpuWrite;
            owner        <= OwnerCpu;
          end else if (grantLdr) begin
            ramAddress   <= ldrAddress;
            ramDataIn    <= ldrDataIn;
            latchedWrite <= ldrWrite;
            ramIsReading <= ~ldrWrite;
            owner        <= OwnerLdr;
          end else begin
            owner        <= OwnerNone;
            ramIsReading <= 1'b1;
          end
        end
        ISSUE: begin
          ramIsReading <= 1'b1;
          waitCount    <= '0;
        end
        WAIT: begin
          if (lastWait) begin
            if (!latchedWrite) begin
              if (owner == OwnerCpu) begin
                cpuDataOut <= ramDataOut;
              end else begin
                ldrDataOut <= ramDataOut;
              end
            end
            cpuDone <= (owner == OwnerCpu);
            ldrDone <= (owner == OwnerLdr);
          end else begin
            waitCount <= waitCount + 1'b1;
          end
        end
        DONE: begin
          owner <= OwnerNone;
        end
        default: begin
          owner <= OwnerNone;
        end
      endcase
    end
  end

endmodule
